logic_unit: RTL and testbench



---
 rtl/logic_unit_if.sv | 64 ++++++
 rtl/logic_unit.sv | 113 +++++++++++
 tb/tb_logic_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_if
// Purpose  : Handshake and data bundle for the logic_unit datapath stage.
//            Carries the operand-side valid/ready pair, the operands and
//            control bits, and the result-side valid/ready pair with the
//            registered result and its flags.
// Ports    : (interface signals)
//            in_valid/in_ready     operand handshake
//            a, b, op              operands and opcode
//            acc_en, acc_clr       accumulator control
//            out_valid/out_ready   result handshake
//            c, zero, parity       registered result and flags
// Modports : master - operand producer / result consumer
//            slave  - the logic unit itself
// Revision : 1.0 - initial release
// ============================================================================
interface logic_unit_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             acc_en;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] c;
   logic             zero;
   logic             parity;

   modport master (
      output in_valid,
      input  in_ready,
      output a,
      output b,
      output op,
      output acc_en,
      output acc_clr,
      input  out_valid,
      output out_ready,
      input  c,
      input  zero,
      input  parity
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  a,
      input  b,
      input  op,
      input  acc_en,
      input  acc_clr,
      output out_valid,
      input  out_ready,
      output c,
      output zero,
      output parity
   );
endinterface
`default_nettype wire

// File: rtl/logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit
// Purpose  : Registered WIDTH-bit bitwise logic unit with a valid/ready
//            handshake, a one-entry output register with backpressure,
//            zero/parity flags and an accumulate mode that feeds the
//            previous result back as operand B.
// Ports    : clk  - single clock, rising edge
//            rst  - synchronous, active-high reset
//            bus  - logic_unit_if.slave (operands in, result out)
// Params   : WIDTH    - operand/result width (>= 1)
//            ACC_INIT - accumulator value after reset or clear
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  wire logic        clk,
   input  wire logic        rst,
   logic_unit_if.slave      bus
);

   // Opcode encoding
   localparam logic [2:0] c_OP_AND  = 3'd0;
   localparam logic [2:0] c_OP_OR   = 3'd1;
   localparam logic [2:0] c_OP_XOR  = 3'd2;
   localparam logic [2:0] c_OP_NAND = 3'd3;
   localparam logic [2:0] c_OP_NOR  = 3'd4;
   localparam logic [2:0] c_OP_XNOR = 3'd5;
   localparam logic [2:0] c_OP_NOT  = 3'd6;
   localparam logic [2:0] c_OP_PASS = 3'd7;

   // Output register occupancy (the only control state)
   localparam logic [0:0] c_ST_EMPTY = 1'b0;
   localparam logic [0:0] c_ST_FULL  = 1'b1;

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_c;
   logic             r_zero;
   logic             r_parity;
   logic [WIDTH-1:0] r_acc;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_drain;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_result;

   // The output slot is free when empty, or when it is being drained this
   // same cycle, which lets back-to-back results flow at full rate.
   assign w_in_ready = (r_state == c_ST_EMPTY) | bus.out_ready;
   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_drain    = (r_state == c_ST_FULL) & bus.out_ready;

   // A clear in the accepting cycle must already be visible to the
   // operation, so the accumulator path sees ACC_INIT rather than r_acc.
   assign w_b_eff = bus.acc_en ? (bus.acc_clr ? ACC_INIT : r_acc) : bus.b;

   always_comb begin
      w_result = '0;
      case (bus.op)
         c_OP_AND:  w_result = bus.a & w_b_eff;
         c_OP_OR:   w_result = bus.a | w_b_eff;
         c_OP_XOR:  w_result = bus.a ^ w_b_eff;
         c_OP_NAND: w_result = ~(bus.a & w_b_eff);
         c_OP_NOR:  w_result = ~(bus.a | w_b_eff);
         c_OP_XNOR: w_result = ~(bus.a ^ w_b_eff);
         c_OP_NOT:  w_result = ~bus.a;
         c_OP_PASS: w_result = bus.a;
         default:   w_result = '0;
      endcase
   end

   // Output register stage: result and flags are loaded together so the
   // flags always describe the value currently on c.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= c_ST_EMPTY;
         r_c      <= '0;
         r_zero   <= 1'b1;
         r_parity <= 1'b0;
      end else if (w_accept) begin
         r_state  <= c_ST_FULL;
         r_c      <= w_result;
         r_zero   <= (w_result == '0);
         r_parity <= ^w_result;
      end else if (w_drain) begin
         // Data is kept so c/zero/parity stay at their last value.
         r_state  <= c_ST_EMPTY;
      end
   end

   // Accumulator tracks every accepted result, whether or not acc_en was
   // used; a clear only takes effect in cycles with no accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= ACC_INIT;
      end else if (w_accept) begin
         r_acc <= w_result;
      end else if (bus.acc_clr) begin
         r_acc <= ACC_INIT;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == c_ST_FULL);
   assign bus.c         = r_c;
   assign bus.zero      = r_zero;
   assign bus.parity    = r_parity;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit
// Purpose  : Self-checking bench for logic_unit (WIDTH = 8, ACC_INIT = 0).
//            Directed steps from the block's test plan followed by random
//            traffic, all compared against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit;

   localparam int         W    = 8;
   localparam logic [7:0] INIT = 8'h00;

   logic clk;
   logic rst;

   logic_unit_if #(.WIDTH(W)) bus ();

   logic_unit #(.WIDTH(W), .ACC_INIT(INIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model state: slot occupancy, held result, accumulator.
   bit         m_init  = 1'b0;
   bit         m_full  = 1'b0;
   logic [7:0] m_c     = 8'h00;
   logic [7:0] m_acc   = 8'h00;

   function automatic logic [7:0] ref_op(input logic [2:0] op,
                                         input logic [7:0] x,
                                         input logic [7:0] y);
      logic [7:0] r;
      case (op)
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: r = x ^ y;
         3'd3: r = ~(x & y);
         3'd4: r = ~(x | y);
         3'd5: r = ~(x ^ y);
         3'd6: r = ~x;
         default: r = x;
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, check in_ready, clock, advance model, check
   // registered outputs.
   task automatic step(input logic iv, input logic [7:0] ia,
                       input logic [7:0] ib, input logic [2:0] iop,
                       input logic ae, input logic ac, input logic ordy,
                       input logic irst);
      bit         rdy, acc_ok;
      logic [7:0] beff, r;
      bus.in_valid  = iv;
      bus.a         = ia;
      bus.b         = ib;
      bus.op        = iop;
      bus.acc_en    = ae;
      bus.acc_clr   = ac;
      bus.out_ready = ordy;
      rst           = irst;
      #1;
      rdy = !m_full || ordy;
      if (m_init) check("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
      @(posedge clk);
      if (irst) begin
         m_init = 1'b1;
         m_full = 1'b0;
         m_c    = 8'h00;
         m_acc  = INIT;
      end else begin
         acc_ok = iv && rdy;
         beff   = ae ? (ac ? INIT : m_acc) : ib;
         r      = ref_op(iop, ia, beff);
         if (acc_ok) begin
            m_full = 1'b1;
            m_c    = r;
            m_acc  = r;
         end else begin
            if (m_full && ordy) m_full = 1'b0;
            if (ac) m_acc = INIT;
         end
      end
      #1;
      if (m_init) begin
         check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_full});
         check("c",         {24'd0, bus.c},         {24'd0, m_c});
         check("zero",      {31'd0, bus.zero},      {31'd0, (m_c == 8'h00)});
         check("parity",    {31'd0, bus.parity},    {31'd0, ^m_c});
      end
   endtask

   logic [7:0] sweep_exp [8];

   initial begin
      sweep_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
      bus.acc_en = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b0;

      // Reset
      step(0, 8'h00, 8'h00, 3'd0, 0, 0, 1, 1);
      step(0, 8'h00, 8'h00, 3'd0, 0, 0, 1, 1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_zero",      {31'd0, bus.zero},      32'd1);
      step(0, 8'h00, 8'h00, 3'd0, 0, 0, 1, 0);
      check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);

      // Op sweep, back to back
      for (int k = 0; k < 8; k++) begin
         step(1, 8'hF0, 8'hCC, 3'(k), 0, 0, 1, 0);
         check("sweep_c",     {24'd0, bus.c},         {24'd0, sweep_exp[k]});
         check("sweep_valid", {31'd0, bus.out_valid}, 32'd1);
      end

      // Flags
      step(1, 8'h0F, 8'hF0, 3'd0, 0, 0, 1, 0);
      check("flag_and_zero",   {31'd0, bus.zero},   32'd1);
      check("flag_and_parity", {31'd0, bus.parity}, 32'd0);
      step(1, 8'h01, 8'h00, 3'd2, 0, 0, 1, 0);
      check("flag_xor_zero",   {31'd0, bus.zero},   32'd0);
      check("flag_xor_parity", {31'd0, bus.parity}, 32'd1);

      // Accumulate (reset first so acc = ACC_INIT)
      step(0, 8'h00, 8'h00, 3'd0, 0, 0, 1, 1);
      step(1, 8'h01, 8'hFF, 3'd2, 1, 0, 1, 0);
      check("acc_c1", {24'd0, bus.c}, 32'h01);
      step(1, 8'h02, 8'hFF, 3'd2, 1, 0, 1, 0);
      check("acc_c2", {24'd0, bus.c}, 32'h03);
      step(1, 8'h04, 8'hFF, 3'd2, 1, 0, 1, 0);
      check("acc_c3", {24'd0, bus.c}, 32'h07);
      step(0, 8'h00, 8'h00, 3'd0, 0, 1, 1, 0);
      step(1, 8'h08, 8'hFF, 3'd2, 1, 0, 1, 0);
      check("acc_clr_c", {24'd0, bus.c}, 32'h08);

      // Backpressure
      step(1, 8'hAA, 8'h00, 3'd7, 0, 0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         step(1, 8'h55, 8'h00, 3'd7, 0, 0, 0, 0);
         check("bp_c",        {24'd0, bus.c},        32'hAA);
         check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      step(1, 8'h55, 8'h00, 3'd7, 0, 0, 1, 0);
      check("bp_release_c", {24'd0, bus.c}, 32'h55);

      // Reset mid-operation
      step(1, 8'h77, 8'h00, 3'd7, 0, 0, 0, 1);
      check("midrst_valid",  {31'd0, bus.out_valid}, 32'd0);
      check("midrst_c",      {24'd0, bus.c},         32'h00);
      check("midrst_zero",   {31'd0, bus.zero},      32'd1);
      check("midrst_parity", {31'd0, bus.parity},    32'd0);
      step(1, 8'h00, 8'h00, 3'd7, 1, 0, 1, 0);
      check("midrst_acc",    {24'd0, bus.c},         {24'd0, INIT});

      // Simultaneous clear and accept
      step(1, 8'h0F, 8'h00, 3'd7, 0, 0, 1, 0);
      step(1, 8'h30, 8'h00, 3'd1, 1, 1, 1, 0);
      check("clracc_c", {24'd0, bus.c}, 32'h30);
      step(1, 8'h00, 8'h00, 3'd2, 1, 0, 1, 0);
      check("clracc_acc", {24'd0, bus.c}, 32'h30);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
              3'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
